// File: rtl/mem_access_ctrl_pkg.sv
// mem_pkg: shared definitions for the M-stage memory access controller.
//   - byte_op encodings (size in bits [1:0], sign request in bit [2])
//   - controller state encoding
//   - size-decode helpers and the misalignment predicate
package mem_pkg;

  localparam logic [2:0] BOP_W  = 3'b000;
  localparam logic [2:0] BOP_BU = 3'b001;
  localparam logic [2:0] BOP_HU = 3'b010;
  localparam logic [2:0] BOP_B  = 3'b101;
  localparam logic [2:0] BOP_H  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Any code whose low bits are neither 01 nor 10 behaves as a word access.
  function automatic logic is_byte_op(input logic [2:0] op);
    return op[1:0] == 2'b01;
  endfunction

  function automatic logic is_half_op(input logic [2:0] op);
    return op[1:0] == 2'b10;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [2:0] op);
    logic bad;
    if (is_byte_op(op))      bad = 1'b0;
    else if (is_half_op(op)) bad = addr_lo[0];
    else                     bad = (addr_lo != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// load_ext: combinational load-lane select and sign/zero extension.
//   addr_lo : byte offset of the access within the word
//   byte_op : access size/sign code (mem_pkg BOP_*)
//   word    : raw 32-bit word from the bus
//   result  : extended load value
module load_ext
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  byte_op,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sx;

  always_comb begin
    byte_sel = word[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
    endcase
  end

  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];
  assign sx       = byte_op[2];

  always_comb begin
    result = word;
    if (is_byte_op(byte_op))
      result = {{24{sx & byte_sel[7]}}, byte_sel};
    else if (is_half_op(byte_op))
      result = {{16{sx & half_sel[15]}}, half_sel};
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequences M-stage loads/stores onto a req/ack word bus.
//   Pipeline side : mem_re, mem_we, addr, wdata, byte_op, flush in;
//                   stall, rdata, rdata_valid, exc_adel, exc_ades, exc_bus out.
//   Bus side      : bus_req, bus_we, bus_addr, bus_byteen, bus_wdata out;
//                   bus_ack, bus_rdata in.
//   TIMEOUT       : REQ/DRAIN cycles without ack before the access aborts.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  byte_op,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic        we_q;
  logic        tmo_q;
  logic [1:0]  alo_q;
  logic [2:0]  bop_q;
  logic [3:0]  byteen_q;
  logic [31:0] ext_data;

  logic        access;
  logic        misal;
  logic        start;
  logic        timeout_hit;
  logic        capture;

  function automatic logic [3:0] lane_en(input logic [1:0] a, input logic [2:0] op);
    logic [3:0] be;
    if (is_byte_op(op))      be = 4'b0001 << a;
    else if (is_half_op(op)) be = a[1] ? 4'b1100 : 4'b0011;
    else                     be = 4'b1111;
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [2:0] op);
    logic [31:0] r;
    if (is_byte_op(op))      r = {4{d[7:0]}};
    else if (is_half_op(op)) r = {2{d[15:0]}};
    else                     r = d;
    return r;
  endfunction

  load_ext u_load_ext (
    .addr_lo (alo_q),
    .byte_op (bop_q),
    .word    (bus_rdata),
    .result  (ext_data)
  );

  assign access      = mem_re | mem_we;
  assign misal       = is_misaligned(addr[1:0], byte_op);
  assign start       = (state == ST_IDLE) & access & ~misal & ~flush;
  assign timeout_hit = (cnt == TMO_LAST) & ~bus_ack;
  // A flushed instruction's load result is never written back.
  assign capture     = (state == ST_REQ) & bus_ack & ~flush & ~we_q;

  // Bus qualifiers come from the latched request so they hold steady until ack.
  assign bus_we      = bus_req & we_q;
  assign bus_byteen  = bus_req ? byteen_q : 4'b0000;

  always_comb begin
    state_nx    = state;
    stall       = 1'b0;
    bus_req     = 1'b0;
    exc_adel    = 1'b0;
    exc_ades    = 1'b0;
    exc_bus     = 1'b0;
    rdata_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (access & misal) begin
          exc_adel = ~mem_we;
          exc_ades = mem_we;
        end else if (start) begin
          stall    = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        // Ack together with flush: transfer is over, just drop the result.
        if (bus_ack)          state_nx = flush ? ST_IDLE : ST_DONE;
        else if (timeout_hit) state_nx = ST_DONE;
        else if (flush)       state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_ack)          state_nx = ST_IDLE;
        else if (timeout_hit) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx    = ST_IDLE;
        rdata_valid = ~we_q & ~tmo_q;
        exc_bus     = tmo_q;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      tmo_q     <= 1'b0;
      alo_q     <= '0;
      bop_q     <= '0;
      byteen_q  <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata     <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        cnt       <= '0;
        we_q      <= mem_we;
        tmo_q     <= 1'b0;
        alo_q     <= addr[1:0];
        bop_q     <= byte_op;
        byteen_q  <= mem_we ? lane_en(addr[1:0], byte_op) : 4'b0000;
        bus_addr  <= {addr[31:2], 2'b00};
        bus_wdata <= lane_data(wdata, byte_op);
      end else if (bus_req) begin
        cnt <= cnt + 16'd1;
      end
      if (bus_req & timeout_hit)
        tmo_q <= 1'b1;
      if (capture)
        rdata <= ext_data;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_re, mem_we, flush;
  logic [31:0] addr, wdata;
  logic [2:0]  byte_op;
  logic        stall, rdata_valid, exc_adel, exc_ades, exc_bus;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;

  always #5 clk = ~clk;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .mem_re(mem_re), .mem_we(mem_we), .addr(addr),
    .wdata(wdata), .byte_op(byte_op), .flush(flush), .stall(stall),
    .rdata(rdata), .rdata_valid(rdata_valid), .exc_adel(exc_adel),
    .exc_ades(exc_ades), .exc_bus(exc_bus), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Expected outputs for the current cycle, written by the stimulus process.
  bit          chk_en = 1'b0;
  bit          exp_rst, exp_stall, exp_req, exp_we, exp_rv, exp_bus, exp_adel, exp_ades;
  logic [31:0] exp_addr, exp_wd, exp_rd;
  logic [3:0]  exp_be;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",       32'(stall),       32'(exp_stall));
      chk("bus_req",     32'(bus_req),     32'(exp_req));
      chk("exc_adel",    32'(exc_adel),    32'(exp_adel));
      chk("exc_ades",    32'(exc_ades),    32'(exp_ades));
      chk("exc_bus",     32'(exc_bus),     32'(exp_bus));
      chk("rdata_valid", 32'(rdata_valid), 32'(exp_rv));
      if (exp_req) begin
        chk("bus_we",     32'(bus_we),     32'(exp_we));
        chk("bus_addr",   bus_addr,        exp_addr);
        chk("bus_byteen", 32'(bus_byteen), 32'(exp_be));
        if (exp_we) chk("bus_wdata", bus_wdata, exp_wd);
      end else begin
        chk("bus_we_idle",     32'(bus_we),     32'd0);
        chk("bus_byteen_idle", 32'(bus_byteen), 32'd0);
      end
      if (exp_rv) chk("rdata", rdata, exp_rd);
      if (exp_rst) begin
        chk("rst_rdata",     rdata,     32'd0);
        chk("rst_bus_addr",  bus_addr,  32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
      end
    end
  end

  // Reference model: access size/lanes/extension straight from the rules.
  function automatic int size_of(input logic [2:0] op);
    if (op[1:0] == 2'b01) return 1;
    if (op[1:0] == 2'b10) return 2;
    return 4;
  endfunction

  function automatic bit m_misal(input logic [31:0] a, input logic [2:0] op);
    return (a % size_of(op)) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] op);
    int s = size_of(op);
    if (s == 1) return 4'(1 << a[1:0]);
    if (s == 2) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [2:0] op);
    int s = size_of(op);
    if (s == 1) return (d & 32'hFF) * 32'h01010101;
    if (s == 2) return (d & 32'hFFFF) * 32'h00010001;
    return d;
  endfunction

  function automatic logic [31:0] m_ld(input logic [31:0] w, input logic [31:0] a, input logic [2:0] op);
    int s = size_of(op);
    logic [31:0] v;
    if (s == 4) return w;
    v = (s == 1) ? ((w >> (8 * a[1:0])) & 32'hFF) : ((w >> (16 * a[1])) & 32'hFFFF);
    if (op[2] && v[8*s-1]) v = v | (32'hFFFFFFFF << (8 * s));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_exp();
    exp_rst = 0; exp_stall = 0; exp_req = 0; exp_we = 0; exp_rv = 0;
    exp_bus = 0; exp_adel = 0; exp_ades = 0;
    exp_addr = '0; exp_wd = '0; exp_rd = '0; exp_be = '0;
  endtask

  task automatic idle_inputs();
    mem_re = 0; mem_we = 0; flush = 0; bus_ack = 0;
  endtask

  // One complete aligned access. ack_at/flush_at are 1-based bus-cycle
  // indices (0 = never). Length of the bus phase, abort and completion
  // follow directly from ack position, flush position and TO.
  task automatic xfer(input bit st, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] op, input logic [31:0] rb,
                      input int ack_at, input int flush_at,
                      input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
    bit acked, flushed, done;
    int n;
    acked   = (ack_at != 0) && (ack_at <= TO);
    n       = acked ? ack_at : TO;
    flushed = (flush_at != 0) && (flush_at <= n);
    done    = !acked || !flushed;
    tick();
    mem_re = !st; mem_we = st; addr = a; wdata = wd; byte_op = op;
    flush = 0; bus_ack = 0; bus_rdata = $urandom;
    clr_exp(); exp_stall = 1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (flushed && i > flush_at) begin mem_re = 0; mem_we = 0; end
      flush     = (i == flush_at);
      bus_ack   = (i == ack_at);
      bus_rdata = (i == ack_at) ? rb : $urandom;
      clr_exp();
      exp_stall = 1; exp_req = 1; exp_we = st;
      exp_addr  = a & 32'hFFFF_FFFC;
      exp_be    = st ? ebe : 4'b0000;
      exp_wd    = ewd;
    end
    if (done) begin
      tick();
      flush = 0; bus_ack = 0; bus_rdata = $urandom;
      clr_exp();
      exp_rv = !st && acked;
      exp_rd = erd;
      exp_bus = !acked;
    end
    tick();
    idle_inputs();
    clr_exp();
  endtask

  task automatic misal_access(input bit st, input logic [31:0] a, input logic [2:0] op);
    tick();
    mem_re = !st; mem_we = st; addr = a; byte_op = op; wdata = $urandom;
    flush = 0; bus_ack = 0;
    clr_exp(); exp_adel = !st; exp_ades = st;
    tick();
    idle_inputs();
    clr_exp();
  endtask

  initial begin
    bit          st;
    logic [2:0]  op;
    logic [31:0] a, wd, rb;
    int          ack_at, flush_at, kind;

    reset = 1; idle_inputs(); addr = '0; wdata = '0; byte_op = '0; bus_rdata = '0;
    clr_exp();
    tick();
    chk_en = 1; exp_rst = 1;
    tick();
    reset = 0;
    tick();
    clr_exp();

    // lb 0x1003, ack on third bus cycle
    xfer(0, 32'h0000_1003, 32'h0, 3'b101, 32'h80FF_1234, 3, 0, 4'b0000, 32'h0, 32'hFFFF_FF80);
    // sh 0x2002, ack on first bus cycle
    xfer(1, 32'h0000_2002, 32'h0000_BEEF, 3'b110, 32'h0, 1, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    // sb lane 1 and sw
    xfer(1, 32'h0000_3001, 32'h1234_56AB, 3'b001, 32'h0, 2, 0, 4'b0010, 32'hABAB_ABAB, 32'h0);
    xfer(1, 32'h0000_3004, 32'hCAFE_F00D, 3'b000, 32'h0, 1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);
    // lh upper half, negative
    xfer(0, 32'h0000_4002, 32'h0, 3'b110, 32'h8001_7FFF, 2, 0, 4'b0000, 32'h0, 32'hFFFF_8001);
    // misaligned lw / sh
    misal_access(0, 32'h0000_0001, 3'b000);
    misal_access(1, 32'h0000_0003, 3'b110);
    // lhu flushed in first bus cycle, ack two cycles later
    xfer(0, 32'h0000_0002, 32'h0, 3'b010, 32'hA5A5_0000, 3, 1, 4'b0000, 32'h0, 32'h0);
    // lw that never sees ack
    xfer(0, 32'h0000_0040, 32'h0, 3'b000, 32'h0, 0, 0, 4'b0000, 32'h0, 32'h0);
    // ack on the last permitted cycle still completes
    xfer(0, 32'h0000_0044, 32'h0, 3'b000, 32'h1357_9BDF, TO, 0, 4'b0000, 32'h0, 32'h1357_9BDF);

    // reset while in REQ
    tick();
    mem_re = 1; mem_we = 0; addr = 32'h0000_0100; byte_op = 3'b000; flush = 0; bus_ack = 0;
    clr_exp(); exp_stall = 1;
    tick();
    clr_exp(); exp_stall = 1; exp_req = 1; exp_addr = 32'h0000_0100; exp_be = 4'b0000;
    tick();
    reset = 1;
    tick();
    reset = 0; idle_inputs();
    clr_exp(); exp_rst = 1;
    tick();
    clr_exp();
    xfer(0, 32'h0000_0001, 32'h0, 3'b001, 32'h0000_9900, 1, 0, 4'b0000, 32'h0, 32'h0000_0099);

    // randomized traffic
    for (int t = 0; t < 250; t++) begin
      kind = $urandom_range(0, 9);
      op   = 3'($urandom_range(0, 7));
      a    = $urandom;
      st   = 1'($urandom_range(0, 1));
      if (kind == 0) begin
        if (size_of(op) == 1) op = 3'b000;
        if (!m_misal(a, op)) a = a | 32'h1;
        misal_access(st, a, op);
      end else if (kind == 1) begin
        // flushed request in IDLE must not start
        tick();
        a = a & 32'hFFFF_FFFC;
        mem_re = !st; mem_we = st; addr = a; byte_op = op; flush = 1; bus_ack = 0;
        clr_exp();
        tick();
        idle_inputs();
      end else begin
        a  = a - (a % size_of(op));
        wd = $urandom;
        rb = $urandom;
        ack_at   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TO + 1);
        flush_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO) : 0;
        xfer(st, a, wd, op, rb, ack_at, flush_at, m_be(a, op), m_wd(wd, op), m_ld(rb, a, op));
      end
    end

    tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
